// File: rtl/gshare_btb_predictor_pkg.sv
// gshare_btb_predictor_pkg: shared parameter defaults, FSM state type and sizing helpers
package gshare_btb_predictor_pkg;
    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_BTB_IDX_W = 7;
    localparam int DEF_TAG_W     = 8;
    localparam int DEF_PHT_IDX_W = 9;
    localparam int DEF_HIST_W    = 8;
    localparam int DEF_CNT_W     = 2;

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    // Weakly-taken counter value: only the MSB set
    function automatic int cnt_init_val(int w);
        return 1 << (w - 1);
    endfunction

    function automatic int max_w(int a, int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/gshare_btb_predictor_if.sv
// gshare_btb_predictor_if: fetch-predict and EX-train signal bundle
interface gshare_btb_predictor_if
    import gshare_btb_predictor_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int HIST_W = DEF_HIST_W
);
    logic              rdy;
    logic              if_valid;
    logic [ADDR_W-1:0] if_pc;
    logic              pre_jmp_status;
    logic [ADDR_W-1:0] pre_jmp_target;
    logic [HIST_W-1:0] pre_ghr;
    logic              ex_valid;
    logic [ADDR_W-1:0] ex_pc;
    logic              ex_is_br;
    logic              ex_taken;
    logic [ADDR_W-1:0] ex_target;
    logic [HIST_W-1:0] ex_ghr;
    logic              ex_mispredict;
    logic              init_busy;

    modport master (
        output rdy, if_valid, if_pc, ex_valid, ex_pc, ex_is_br, ex_taken, ex_target, ex_ghr, ex_mispredict,
        input  pre_jmp_status, pre_jmp_target, pre_ghr, init_busy
    );

    modport slave (
        input  rdy, if_valid, if_pc, ex_valid, ex_pc, ex_is_br, ex_taken, ex_target, ex_ghr, ex_mispredict,
        output pre_jmp_status, pre_jmp_target, pre_ghr, init_busy
    );
endinterface

// File: rtl/gshare_btb_predictor_pht.sv
// gshare_btb_predictor_pht: saturating-counter pattern history table, async read.
module gshare_btb_predictor_pht
    import gshare_btb_predictor_pkg::*;
#(
    parameter int PHT_IDX_W = DEF_PHT_IDX_W,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 init_we,
    input  logic [PHT_IDX_W-1:0] init_idx,
    input  logic                 trn_we,
    input  logic [PHT_IDX_W-1:0] trn_idx,
    input  logic                 trn_taken,
    input  logic [PHT_IDX_W-1:0] rd_idx,
    output logic [CNT_W-1:0]     rd_cnt
);
    localparam int                N        = 1 << PHT_IDX_W;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(cnt_init_val(CNT_W));

    logic [CNT_W-1:0] pht_q [N];
    logic [CNT_W-1:0] pht_d [N];
    logic [CNT_W-1:0] cur, nxt;

    assign rd_cnt = pht_q[rd_idx];
    assign cur    = pht_q[trn_idx];
    assign nxt    = trn_taken ? (&cur ? cur : cur + 1'b1) : (|cur ? cur - 1'b1 : cur);

    always_comb begin
        pht_d = pht_q;
        if (init_we)
            pht_d[init_idx] = CNT_INIT;
        else if (trn_we)
            pht_d[trn_idx] = nxt;
    end

    always_ff @(posedge clk)
        pht_q <= pht_d;
endmodule

// File: rtl/gshare_btb_predictor.sv
// gshare_btb_predictor: BTB + gshare PHT fetch predictor with speculative GHR and repair.
module gshare_btb_predictor
    import gshare_btb_predictor_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int BTB_IDX_W = DEF_BTB_IDX_W,
    parameter int TAG_W     = DEF_TAG_W,
    parameter int PHT_IDX_W = DEF_PHT_IDX_W,
    parameter int HIST_W    = DEF_HIST_W,
    parameter int CNT_W     = DEF_CNT_W
) (
    input logic                  clk,
    input logic                  rst,
    gshare_btb_predictor_if.slave bus
);
    localparam int BTB_N   = 1 << BTB_IDX_W;
    localparam int SWEEP_W = max_w(BTB_IDX_W, PHT_IDX_W);

    state_e               state_q, state_d;
    logic [SWEEP_W-1:0]   ptr_q, ptr_d;
    logic [HIST_W-1:0]    ghr_q, ghr_d;
    logic                 btb_valid_q [BTB_N];
    logic                 btb_valid_d [BTB_N];
    logic [TAG_W-1:0]     btb_tag_q [BTB_N];
    logic [TAG_W-1:0]     btb_tag_d [BTB_N];
    logic [ADDR_W-1:0]    btb_tgt_q [BTB_N];
    logic [ADDR_W-1:0]    btb_tgt_d [BTB_N];

    logic                 run, hit, taken, trn, repair, btb_init, pht_init;
    logic [BTB_IDX_W-1:0] bi, ex_bi;
    logic [TAG_W-1:0]     tag, ex_tag;
    logic [PHT_IDX_W-1:0] pi, ex_pi;
    logic [CNT_W-1:0]     cnt;
    logic                 unused_ok;

    assign run    = state_q == ST_RUN;
    assign bi     = bus.if_pc[BTB_IDX_W+1:2];
    assign tag    = bus.if_pc[BTB_IDX_W+TAG_W+1:BTB_IDX_W+2];
    assign pi     = bus.if_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr_q);
    assign ex_bi  = bus.ex_pc[BTB_IDX_W+1:2];
    assign ex_tag = bus.ex_pc[BTB_IDX_W+TAG_W+1:BTB_IDX_W+2];
    assign ex_pi  = bus.ex_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(bus.ex_ghr);

    // Tables hold garbage during the sweep, so every prediction is gated by run
    assign hit   = run && btb_valid_q[bi] && btb_tag_q[bi] == tag;
    assign taken = hit && cnt[CNT_W-1];

    assign bus.pre_jmp_status = taken;
    assign bus.pre_jmp_target = taken ? btb_tgt_q[bi] : '0;
    assign bus.pre_ghr        = ghr_q;
    assign bus.init_busy      = !run;

    assign trn      = bus.rdy && run && bus.ex_valid && bus.ex_is_br;
    assign repair   = trn && bus.ex_mispredict;
    // The sweep runs over the larger table; the smaller one ignores pointers past its end
    assign btb_init = bus.rdy && !run && (ptr_q >> BTB_IDX_W) == '0;
    assign pht_init = bus.rdy && !run && (ptr_q >> PHT_IDX_W) == '0;

    assign unused_ok = ^{bus.if_pc, bus.ex_pc, bus.ex_ghr};

    gshare_btb_predictor_pht #(
        .PHT_IDX_W (PHT_IDX_W),
        .CNT_W     (CNT_W)
    ) u_pht (
        .clk       (clk),
        .init_we   (pht_init),
        .init_idx  (ptr_q[PHT_IDX_W-1:0]),
        .trn_we    (trn),
        .trn_idx   (ex_pi),
        .trn_taken (bus.ex_taken),
        .rd_idx    (pi),
        .rd_cnt    (cnt)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (bus.rdy && !run) begin
            ptr_d   = ptr_q + 1'b1;
            state_d = &ptr_q ? ST_RUN : ST_INIT;
        end
    end

    // Repair restores the history as it stood at the mispredicted fetch plus the true outcome
    assign ghr_d = repair ? {bus.ex_ghr[HIST_W-2:0], bus.ex_taken} :
                   (bus.rdy && bus.if_valid && hit) ? {ghr_q[HIST_W-2:0], taken} : ghr_q;

    always_comb begin
        btb_valid_d = btb_valid_q;
        btb_tag_d   = btb_tag_q;
        btb_tgt_d   = btb_tgt_q;
        if (btb_init)
            btb_valid_d[ptr_q[BTB_IDX_W-1:0]] = 1'b0;
        else if (trn && bus.ex_taken) begin
            btb_valid_d[ex_bi] = 1'b1;
            btb_tag_d[ex_bi]   = ex_tag;
            btb_tgt_d[ex_bi]   = bus.ex_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
            ghr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ghr_q   <= ghr_d;
        end
    end

    always_ff @(posedge clk) begin
        btb_valid_q <= btb_valid_d;
        btb_tag_q   <= btb_tag_d;
        btb_tgt_q   <= btb_tgt_d;
    end
endmodule

// File: tb/tb_gshare_btb_predictor.sv
// tb_gshare_btb_predictor: directed + random checks against a table-level predictor model.
module tb_gshare_btb_predictor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gshare_btb_predictor_if bus();
    gshare_btb_predictor dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    int          pht_m [512];
    bit          vld_m [128];
    int          tag_m [128];
    logic [31:0] tgt_m [128];
    int          ghr_m;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic model_init();
        foreach (pht_m[i]) pht_m[i] = 2;
        foreach (vld_m[i]) vld_m[i] = 1'b0;
        ghr_m = 0;
    endtask

    task automatic model_pred(input logic [31:0] pc, output bit h, output bit t, output logic [31:0] tg);
        int bi = int'((pc >> 2) & 127);
        int tp = int'((pc >> 9) & 255);
        int pi = int'((pc >> 2) & 511) ^ ghr_m;
        h  = vld_m[bi] && tag_m[bi] == tp;
        t  = h && pht_m[pi] >= 2;
        tg = t ? tgt_m[bi] : 32'h0;
    endtask

    task automatic cmp(input string name);
        bit h, t;
        logic [31:0] tg;
        #1;
        model_pred(bus.if_pc, h, t, tg);
        chk({name, "_status"}, 32'(bus.pre_jmp_status), 32'(t));
        chk({name, "_target"}, bus.pre_jmp_target, tg);
        chk({name, "_ghr"}, 32'(bus.pre_ghr), 32'(ghr_m));
    endtask

    task automatic step();
        bit h, t;
        logic [31:0] tg;
        int pi, bi;
        model_pred(bus.if_pc, h, t, tg);
        if (bus.rdy) begin
            if (bus.ex_valid && bus.ex_is_br && bus.ex_mispredict)
                ghr_m = int'(((bus.ex_ghr << 1) | bus.ex_taken) & 255);
            else if (bus.if_valid && h)
                ghr_m = ((ghr_m << 1) | int'(t)) & 255;
            if (bus.ex_valid && bus.ex_is_br) begin
                pi = int'((bus.ex_pc >> 2) & 511) ^ int'(bus.ex_ghr);
                if (bus.ex_taken) begin
                    if (pht_m[pi] < 3) pht_m[pi]++;
                    bi = int'((bus.ex_pc >> 2) & 127);
                    vld_m[bi] = 1'b1;
                    tag_m[bi] = int'((bus.ex_pc >> 9) & 255);
                    tgt_m[bi] = bus.ex_target;
                end else if (pht_m[pi] > 0) pht_m[pi]--;
            end
        end
        tick();
    endtask

    task automatic ex_set(input bit v, input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                          input logic [7:0] g, input bit mis);
        bus.ex_valid      = v;
        bus.ex_is_br      = v;
        bus.ex_pc         = pc;
        bus.ex_taken      = tk;
        bus.ex_target     = tgt;
        bus.ex_ghr        = g;
        bus.ex_mispredict = mis;
    endtask

    task automatic count_init(input string name);
        int n = 0;
        bit bad = 1'b0;
        while (bus.init_busy === 1'b1 && n < 2000) begin
            if (bus.pre_jmp_status !== 1'b0) bad = 1'b1;
            tick();
            n++;
        end
        chk({name, "_cycles"}, n, 512);
        chk({name, "_nopred"}, 32'(bad), 0);
    endtask

    function automatic logic [31:0] rpc();
        return 32'(($urandom_range(0, 3) << 9) | ($urandom_range(0, 7) << 2));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1);
    end

    initial begin
        bus.rdy      = 1'b1;
        bus.if_valid = 1'b1;
        bus.if_pc    = 32'h100;
        ex_set(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_busy", 32'(bus.init_busy), 1);
        chk("rst_status", 32'(bus.pre_jmp_status), 0);
        chk("rst_target", bus.pre_jmp_target, 0);
        count_init("init");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (256) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_init("restart");
        chk("init_ghr", 32'(bus.pre_ghr), 0);
        bus.if_valid = 1'b0;
        model_init();

        cmp("cold");
        chk("cold_st", 32'(bus.pre_jmp_status), 0);
        ex_set(1, 32'h100, 1, 32'h200, 0, 0);
        step();
        ex_set(0, 0, 0, 0, 0, 0);
        cmp("warm");
        chk("warm_st", 32'(bus.pre_jmp_status), 1);
        chk("warm_tgt", bus.pre_jmp_target, 32'h200);

        ex_set(1, 32'h100, 1, 32'h200, 0, 0);
        step();
        step();
        ex_set(0, 0, 0, 0, 0, 0);
        cmp("sat_hi");
        chk("sat_hi_st", 32'(bus.pre_jmp_status), 1);
        ex_set(1, 32'h100, 0, 0, 0, 0);
        step();
        ex_set(0, 0, 0, 0, 0, 0);
        cmp("dec1");
        chk("dec1_st", 32'(bus.pre_jmp_status), 1);
        ex_set(1, 32'h100, 0, 0, 0, 0);
        step();
        ex_set(0, 0, 0, 0, 0, 0);
        cmp("dec2");
        chk("dec2_st", 32'(bus.pre_jmp_status), 0);
        chk("dec2_tgt", bus.pre_jmp_target, 0);
        ex_set(1, 32'h100, 1, 32'h200, 0, 0);
        step();
        ex_set(0, 0, 0, 0, 0, 0);
        cmp("btb_kept");
        chk("btb_kept_tgt", bus.pre_jmp_target, 32'h200);

        bus.if_pc = 32'h300;
        cmp("alias");
        chk("alias_st", 32'(bus.pre_jmp_status), 0);

        bus.if_pc    = 32'h100;
        bus.if_valid = 1'b1;
        step();
        step();
        step();
        cmp("ghr_shift");
        chk("ghr_shift_val", 32'(bus.pre_ghr), 32'h7);
        ex_set(1, 32'h100, 0, 0, 8'h01, 1);
        step();
        ex_set(0, 0, 0, 0, 0, 0);
        bus.if_valid = 1'b0;
        cmp("repair");
        chk("repair_val", 32'(bus.pre_ghr), 32'h2);

        bus.rdy      = 1'b0;
        bus.if_valid = 1'b1;
        ex_set(1, 32'h500, 1, 32'h900, 8'h55, 1);
        step();
        step();
        step();
        cmp("frozen");
        chk("frozen_ghr", 32'(bus.pre_ghr), 32'h2);
        bus.rdy      = 1'b1;
        bus.if_valid = 1'b0;
        ex_set(0, 0, 0, 0, 0, 0);
        bus.if_pc = 32'h500;
        cmp("frozen_btb");
        chk("frozen_btb_st", 32'(bus.pre_jmp_status), 0);
        bus.if_pc = 32'h100;
        cmp("frozen_pht");

        for (int i = 0; i < 400; i++) begin
            bus.rdy      = $urandom_range(0, 7) != 0;
            bus.if_valid = 1'($urandom_range(0, 1));
            bus.if_pc    = rpc();
            ex_set(1'($urandom_range(0, 1)), rpc(), 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
                   8'($urandom), $urandom_range(0, 3) == 0);
            bus.ex_is_br = $urandom_range(0, 3) != 0;
            cmp("rand");
            step();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
